// File: rtl/laby6.sv
// Registered 2:1 multiplexer: captures i_d0 or i_d1 (chosen by i_a) into o_y
// on every rising i_clk edge; o_y clears asynchronously while i_rst_n is low.
module laby6 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] y_q;

  always_comb begin
    y_next = i_d0;
    if (i_a) y_next = i_d1;
  end

  // The output is taken straight from the flop, so inputs never reach o_y
  // combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) y_q <= '0;
    else          y_q <= y_next;
  end

  assign o_y = y_q;

endmodule

// File: tb/tb_laby6.sv
// Directed bench for laby6: a WIDTH=1 and a WIDTH=8 instance share clock and
// reset; inputs change and outputs are checked 1 time unit after each rising edge.
module tb_laby6;

  logic       clk;
  logic       rst_n;
  logic       a1;
  logic [0:0] d0_1;
  logic [0:0] d1_1;
  logic [0:0] y1;
  logic       a8;
  logic [7:0] d0_8;
  logic [7:0] d1_8;
  logic [7:0] y8;

  int checks = 0;
  int errors = 0;

  laby6 #(.WIDTH(1)) u_dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_a    (a1),
    .i_d0   (d0_1),
    .i_d1   (d1_1),
    .o_y    (y1)
  );

  laby6 #(.WIDTH(8)) u_dut8 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_a    (a8),
    .i_d0   (d0_8),
    .i_d1   (d1_8),
    .o_y    (y8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [0:0] obs, input logic [0:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [0:0] sw_d0  [4];
  logic [0:0] sw_d1  [4];
  logic [0:0] exp_s0 [4];
  logic [0:0] exp_s1 [4];
  logic [7:0] exp_tog;

  initial begin
    sw_d0  = '{1'b0, 1'b1, 1'b0, 1'b1};
    sw_d1  = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_s0 = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_s1 = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held with the "1" input selected: output must stay zero.
    rst_n = 1'b0;
    a1 = 1'b1; d0_1 = 1'b0; d1_1 = 1'b1;
    a8 = 1'b1; d0_8 = 8'h00; d1_8 = 8'hFF;
    #1;
    check1("rst_y1_initial", y1, 1'b0);
    check8("rst_y8_initial", y8, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("rst_hold_y1", y1, 1'b0);
      check8("rst_hold_y8", y8, 8'h00);
    end

    // Reset release with i_a=0, i_d0=1: zero until the first sampled edge.
    rst_n = 1'b1;
    a1 = 1'b0; d0_1 = 1'b1; d1_1 = 1'b0;
    #2;
    check1("release_before_edge", y1, 1'b0);
    tick();
    check1("release_first_edge", y1, 1'b1);

    // Select 0 sweep.
    a1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d0_1 = sw_d0[i]; d1_1 = sw_d1[i];
      tick();
      check1($sformatf("sel0_sweep_%0d", i), y1, exp_s0[i]);
    end

    // Select 1 sweep.
    a1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0_1 = sw_d0[i]; d1_1 = sw_d1[i];
      tick();
      check1($sformatf("sel1_sweep_%0d", i), y1, exp_s1[i]);
    end

    // Latency: a mid-cycle change of i_d0 is invisible until the next edge.
    a1 = 1'b0; d0_1 = 1'b0; d1_1 = 1'b1;
    tick();
    check1("lat_start", y1, 1'b0);
    #3;
    d0_1 = 1'b1;
    #1;
    check1("lat_no_comb_path", y1, 1'b0);
    tick();
    check1("lat_after_edge", y1, 1'b1);

    // WIDTH=8 select toggling; output lags i_a by one cycle.
    d0_8 = 8'h5A; d1_8 = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      a8 = i[0];
      exp_tog = i[0] ? 8'hA5 : 8'h5A;
      tick();
      check8($sformatf("toggle_%0d", i), y8, exp_tog);
    end

    // Unselected input changes have no effect.
    a8 = 1'b1; d1_8 = 8'h3C; d0_8 = 8'hFF;
    tick();
    check8("unsel_d0_ignored", y8, 8'h3C);
    a8 = 1'b0; d0_8 = 8'hC3; d1_8 = 8'h00;
    tick();
    check8("unsel_d1_ignored", y8, 8'hC3);

    // Asynchronous reset mid-cycle while y1 is 1: must clear before the next edge.
    check1("async_pre_y1", y1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_rst_y1", y1, 1'b0);
    check8("async_rst_y8", y8, 8'h00);
    tick();
    check1("async_hold_y1", y1, 1'b0);
    check8("async_hold_y8", y8, 8'h00);

    // Recover and confirm normal capture resumes.
    rst_n = 1'b1;
    a8 = 1'b1; d1_8 = 8'h81;
    tick();
    check8("recover_y8", y8, 8'h81);
    check1("recover_y1", y1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
